// File: rtl/alu_seq_ctrl.sv
// Multi-cycle command sequencer around a 16-bit ALU and an internal register file.
// Commands are accepted over start/busy/done; results are written back to R[rd].
module alu_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    rn,
  input  logic [AW-1:0]    rm,
  input  logic [WIDTH-1:0] imm,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             z,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned NREG = 1 << AW;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    WRITE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q, rn_q, rm_q;
  logic             ill_pend;
  logic             accept, accept_ill;
  logic             done_nxt, err_nxt;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] alu_y;
  logic             alu_z;

  // ALU: compare reuses the subtract path
  always_comb begin
    alu_op = (op_q == 3'b101) ? 2'b01 : op_q[1:0];
    alu_y  = '0;
    case (alu_op)
      2'b00:   alu_y = a_q + b_q;
      2'b01:   alu_y = a_q - b_q;
      2'b10:   alu_y = a_q & b_q;
      default: alu_y = ~b_q;
    endcase
    alu_z = (alu_y == '0);
  end

  // Illegal ops never leave IDLE; ill_pend delays their done/err by one cycle.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    accept_ill = 1'b0;
    done_nxt   = ill_pend;
    err_nxt    = ill_pend;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (op[2:1] == 2'b11) begin
            accept_ill = 1'b1;
          end else if (op == 3'b100) begin
            state_nxt = WRITE;
          end else begin
            state_nxt = LOAD_A;
          end
        end
      end
      LOAD_A: state_nxt = LOAD_B;
      LOAD_B: state_nxt = EXEC;
      EXEC: begin
        if (op_q == 3'b101) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      err      <= 1'b0;
      z        <= 1'b0;
      ill_pend <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      rn_q     <= '0;
      rm_q     <= '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i[AW-1:0]] <= '0;
      end
    end else begin
      state    <= state_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      ill_pend <= accept_ill;
      if (accept) begin
        op_q <= op;
        rd_q <= rd;
        rn_q <= rn;
        rm_q <= rm;
        if (op == 3'b100) begin
          c_q <= imm;
        end
      end
      case (state)
        LOAD_A: a_q <= regs[rn_q];
        LOAD_B: b_q <= regs[rm_q];
        EXEC: begin
          c_q <= alu_y;
          z   <= alu_z;
        end
        WRITE:   regs[rd_q] <= c_q;
        default: ;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign rd_data = regs[rd_addr];

endmodule
